// File: rtl/ex_stage_param.sv
`default_nettype none
// ============================================================================
// Module  : ex_stage_param
// Purpose : Execute stage - ALU, SZCV flags, branch resolve, memory enables,
//           sticky halt and a scanned 7-segment display of the OUT register.
// Revision: 1.0
// ============================================================================
module ex_stage_param #(
   parameter int WIDTH    = 16,
   parameter int RA_W     = 3,
   parameter int NDIGITS  = 4,
   parameter int SCAN_DIV = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [3:0]         opcode,
   input  logic [WIDTH-1:0]   alu1,
   input  logic [WIDTH-1:0]   alu2,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               wr_reg,
   input  logic [RA_W-1:0]    wr_addr,
   input  logic [1:0]         mem_op,
   input  logic [WIDTH-1:0]   mem_addr_in,
   input  logic [WIDTH-1:0]   store_in,
   input  logic               isbranch,
   input  logic [2:0]         cond,
   output logic               out_valid,
   output logic [WIDTH-1:0]   alu_out,
   output logic               wr_reg_out,
   output logic [RA_W-1:0]    wr_addr_out,
   output logic [WIDTH-1:0]   mem_addr,
   output logic [WIDTH-1:0]   store_data,
   output logic               mem_re,
   output logic               mem_we,
   output logic               pcsrc,
   output logic [WIDTH-1:0]   pctarget,
   output logic [3:0]         flags,
   output logic               halted,
   output logic [7:0]         seg,
   output logic [NDIGITS-1:0] dig_sel
);

   localparam int C_SH_W  = $clog2(WIDTH);
   localparam int C_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [C_CNT_W-1:0] C_SCAN_LAST = C_CNT_W'(SCAN_DIV - 1);

   localparam logic [3:0] C_OP_ADD = 4'd0;
   localparam logic [3:0] C_OP_SUB = 4'd1;
   localparam logic [3:0] C_OP_AND = 4'd2;
   localparam logic [3:0] C_OP_OR  = 4'd3;
   localparam logic [3:0] C_OP_XOR = 4'd4;
   localparam logic [3:0] C_OP_CMP = 4'd5;
   localparam logic [3:0] C_OP_MOV = 4'd6;
   localparam logic [3:0] C_OP_SLL = 4'd8;
   localparam logic [3:0] C_OP_SLR = 4'd9;
   localparam logic [3:0] C_OP_SRL = 4'd10;
   localparam logic [3:0] C_OP_SRA = 4'd11;
   localparam logic [3:0] C_OP_IN  = 4'd12;
   localparam logic [3:0] C_OP_OUT = 4'd13;
   localparam logic [3:0] C_OP_HLT = 4'd15;

   logic               out_valid_q,  out_valid_d;
   logic [WIDTH-1:0]   alu_out_q,    alu_out_d;
   logic               wr_reg_out_q, wr_reg_out_d;
   logic [RA_W-1:0]    wr_addr_out_q, wr_addr_out_d;
   logic [WIDTH-1:0]   mem_addr_q,   mem_addr_d;
   logic [WIDTH-1:0]   store_data_q, store_data_d;
   logic               mem_re_q,     mem_re_d;
   logic               mem_we_q,     mem_we_d;
   logic               pcsrc_q,      pcsrc_d;
   logic [WIDTH-1:0]   pctarget_q,   pctarget_d;
   logic [3:0]         flags_q,      flags_d;
   logic               halted_q,     halted_d;
   logic [WIDTH-1:0]   disp_q,       disp_d;
   logic [C_CNT_W-1:0] scan_cnt_q,   scan_cnt_d;
   logic [NDIGITS-1:0] dig_sel_q,    dig_sel_d;
   logic [7:0]         seg_q,        seg_d;

   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_sub;
   logic [C_SH_W-1:0]  w_sh;
   logic [C_SH_W-1:0]  w_sh_m1;
   logic [WIDTH-1:0]   w_msb_probe;
   logic [WIDTH-1:0]   w_lsb_probe;
   logic [WIDTH-1:0]   w_res;
   logic               w_c;
   logic               w_v;
   logic               w_eff_valid;
   logic               w_commit;
   logic               w_flag_wr;
   logic               w_cond_ok;
   logic               w_taken;
   logic [3:0]         w_nib;

   function automatic logic [7:0] seg_encode(input logic [3:0] nib);
      logic [7:0] s;
      case (nib)
         4'h0: s = 8'hFC;  4'h1: s = 8'h60;  4'h2: s = 8'hDA;  4'h3: s = 8'hF2;
         4'h4: s = 8'h66;  4'h5: s = 8'hB6;  4'h6: s = 8'hBE;  4'h7: s = 8'hE0;
         4'h8: s = 8'hFE;  4'h9: s = 8'hF6;  4'hA: s = 8'hEE;  4'hB: s = 8'h3E;
         4'hC: s = 8'h1A;  4'hD: s = 8'h7A;  4'hE: s = 8'h9E;  default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // ALU; shift carries come from probing the operand one position short of the full shift
   always_comb begin
      w_add       = {1'b0, alu1} + {1'b0, alu2};
      w_sub       = {1'b0, alu1} - {1'b0, alu2};
      w_sh        = alu2[C_SH_W-1:0];
      w_sh_m1     = w_sh - 1'b1;
      w_msb_probe = alu1 << w_sh_m1;
      w_lsb_probe = alu1 >> w_sh_m1;
      w_res       = '0;
      w_c         = 1'b0;
      w_v         = 1'b0;
      case (opcode)
         C_OP_ADD: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = (alu1[WIDTH-1] == alu2[WIDTH-1]) && (w_res[WIDTH-1] != alu1[WIDTH-1]);
         end
         C_OP_SUB, C_OP_CMP: begin
            w_res = w_sub[WIDTH-1:0];
            w_c   = w_sub[WIDTH];
            w_v   = (alu1[WIDTH-1] != alu2[WIDTH-1]) && (w_res[WIDTH-1] != alu1[WIDTH-1]);
         end
         C_OP_AND: w_res = alu1 & alu2;
         C_OP_OR:  w_res = alu1 | alu2;
         C_OP_XOR: w_res = alu1 ^ alu2;
         C_OP_MOV: w_res = alu2;
         C_OP_SLL: begin
            w_res = alu1 << w_sh;
            w_c   = (w_sh != '0) && w_msb_probe[WIDTH-1];
         end
         C_OP_SLR: begin
            w_res = (alu1 << w_sh) | (alu1 >> (WIDTH - int'(w_sh)));
            w_c   = (w_sh != '0) && w_msb_probe[WIDTH-1];
         end
         C_OP_SRL: begin
            w_res = alu1 >> w_sh;
            w_c   = (w_sh != '0) && w_lsb_probe[0];
         end
         C_OP_SRA: begin
            w_res = $signed(alu1) >>> w_sh;
            w_c   = (w_sh != '0) && w_lsb_probe[0];
         end
         C_OP_IN:  w_res = in_data;
         C_OP_OUT: w_res = alu1;
         default:  w_res = '0;
      endcase
   end

   always_comb begin
      w_eff_valid = in_valid && !halted_q;
      w_commit    = w_eff_valid && (opcode != C_OP_HLT);
      w_flag_wr   = w_eff_valid && !isbranch &&
                    ((opcode <= C_OP_MOV) || ((opcode >= C_OP_SLL) && (opcode <= C_OP_SRA)));
      case (cond)
         3'd0:    w_cond_ok = flags_q[2];
         3'd1:    w_cond_ok = flags_q[3] ^ flags_q[0];
         3'd2:    w_cond_ok = flags_q[2] | (flags_q[3] ^ flags_q[0]);
         3'd3:    w_cond_ok = !flags_q[2];
         3'd4:    w_cond_ok = 1'b1;
         default: w_cond_ok = 1'b0;
      endcase
      w_taken = w_eff_valid && isbranch && w_cond_ok;
   end

   // Stage registers: flush beats stall; pcsrc never survives a non-normal cycle
   always_comb begin
      out_valid_d   = out_valid_q;
      alu_out_d     = alu_out_q;
      wr_reg_out_d  = wr_reg_out_q;
      wr_addr_out_d = wr_addr_out_q;
      mem_addr_d    = mem_addr_q;
      store_data_d  = store_data_q;
      mem_re_d      = mem_re_q;
      mem_we_d      = mem_we_q;
      pcsrc_d       = 1'b0;
      pctarget_d    = pctarget_q;
      flags_d       = flags_q;
      halted_d      = halted_q;
      disp_d        = disp_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         wr_reg_out_d = 1'b0;
         mem_re_d     = 1'b0;
         mem_we_d     = 1'b0;
      end else if (!stall) begin
         out_valid_d   = w_commit;
         alu_out_d     = w_res;
         wr_reg_out_d  = wr_reg && w_commit;
         wr_addr_out_d = wr_addr;
         mem_addr_d    = mem_addr_in;
         store_data_d  = store_in;
         mem_re_d      = w_commit && (mem_op == 2'd1);
         mem_we_d      = w_commit && (mem_op == 2'd2);
         pcsrc_d       = w_taken;
         if (w_taken) begin
            pctarget_d = store_in;
         end
         if (w_flag_wr) begin
            flags_d = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
         end
         if (w_eff_valid && (opcode == C_OP_OUT)) begin
            disp_d = alu1;
         end
         if (w_eff_valid && (opcode == C_OP_HLT)) begin
            halted_d = 1'b1;
         end
      end
   end

   // Display scan is free-running; seg tracks the next digit so it lines up with dig_sel
   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      dig_sel_d  = dig_sel_q;
      if (scan_cnt_q == C_SCAN_LAST) begin
         scan_cnt_d = '0;
         dig_sel_d  = (dig_sel_q << 1) | (dig_sel_q >> (NDIGITS - 1));
      end
      w_nib = 4'h0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (dig_sel_d[i]) begin
            w_nib = disp_d[i*4 +: 4];
         end
      end
      seg_d = seg_encode(w_nib);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         alu_out_q     <= '0;
         wr_reg_out_q  <= 1'b0;
         wr_addr_out_q <= '0;
         mem_addr_q    <= '0;
         store_data_q  <= '0;
         mem_re_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         pcsrc_q       <= 1'b0;
         pctarget_q    <= '0;
         flags_q       <= 4'h0;
         halted_q      <= 1'b0;
         disp_q        <= '0;
         scan_cnt_q    <= '0;
         dig_sel_q     <= NDIGITS'(1);
         seg_q         <= 8'hFC;
      end else begin
         out_valid_q   <= out_valid_d;
         alu_out_q     <= alu_out_d;
         wr_reg_out_q  <= wr_reg_out_d;
         wr_addr_out_q <= wr_addr_out_d;
         mem_addr_q    <= mem_addr_d;
         store_data_q  <= store_data_d;
         mem_re_q      <= mem_re_d;
         mem_we_q      <= mem_we_d;
         pcsrc_q       <= pcsrc_d;
         pctarget_q    <= pctarget_d;
         flags_q       <= flags_d;
         halted_q      <= halted_d;
         disp_q        <= disp_d;
         scan_cnt_q    <= scan_cnt_d;
         dig_sel_q     <= dig_sel_d;
         seg_q         <= seg_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign alu_out     = alu_out_q;
   assign wr_reg_out  = wr_reg_out_q;
   assign wr_addr_out = wr_addr_out_q;
   assign mem_addr    = mem_addr_q;
   assign store_data  = store_data_q;
   assign mem_re      = mem_re_q;
   assign mem_we      = mem_we_q;
   assign pcsrc       = pcsrc_q;
   assign pctarget    = pctarget_q;
   assign flags       = flags_q;
   assign halted      = halted_q;
   assign seg         = seg_q;
   assign dig_sel     = dig_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_stage_param
// Purpose : Directed vectors with hand-computed expectations, scoreboard checked.
// Revision: 1.0
// ============================================================================
module tb_ex_stage_param;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, in_valid, wr_reg, isbranch;
   logic [3:0]  opcode;
   logic [15:0] alu1, alu2, in_data, mem_addr_in, store_in;
   logic [2:0]  wr_addr, cond;
   logic [1:0]  mem_op;
   logic        out_valid, wr_reg_out, mem_re, mem_we, pcsrc, halted;
   logic [15:0] alu_out, mem_addr, store_data, pctarget;
   logic [2:0]  wr_addr_out;
   logic [3:0]  flags, dig_sel;
   logic [7:0]  seg;

   always #5 clk = ~clk;

   ex_stage_param #(.WIDTH(16), .RA_W(3), .NDIGITS(4), .SCAN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .opcode(opcode), .alu1(alu1), .alu2(alu2), .in_data(in_data), .wr_reg(wr_reg),
      .wr_addr(wr_addr), .mem_op(mem_op), .mem_addr_in(mem_addr_in), .store_in(store_in),
      .isbranch(isbranch), .cond(cond), .out_valid(out_valid), .alu_out(alu_out),
      .wr_reg_out(wr_reg_out), .wr_addr_out(wr_addr_out), .mem_addr(mem_addr),
      .store_data(store_data), .mem_re(mem_re), .mem_we(mem_we), .pcsrc(pcsrc),
      .pctarget(pctarget), .flags(flags), .halted(halted), .seg(seg), .dig_sel(dig_sel)
   );

   typedef struct {
      int          id;
      bit          chk_alu;
      bit          chk_disp;
      logic        out_valid;
      logic [15:0] alu_out;
      logic [3:0]  flags;
      logic        pcsrc;
      logic [15:0] pctarget;
      logic        wr_reg_out;
      logic        mem_re;
      logic        mem_we;
      logic        halted;
      logic [3:0]  dig_sel;
      logic [7:0]  seg;
   } exp_t;

   exp_t sb[$];
   exp_t m;
   int   n_vec = 0;
   int   n_bad = 0;
   logic [7:0] segtab [4] = '{8'h8E, 8'hDA, 8'hEE, 8'h60};

   task automatic chk(input int id, input string f, input logic [15:0] act, input logic [15:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL v%0d %s: got %h expected %h", id, f, act, exp);
      end
   endtask

   // Monitor: one scoreboard entry per clock edge that carries an expectation
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            m = sb.pop_front();
            n_vec++;
            chk(m.id, "out_valid", 16'(out_valid), 16'(m.out_valid));
            chk(m.id, "flags", 16'(flags), 16'(m.flags));
            chk(m.id, "pcsrc", 16'(pcsrc), 16'(m.pcsrc));
            chk(m.id, "pctarget", pctarget, m.pctarget);
            chk(m.id, "wr_reg_out", 16'(wr_reg_out), 16'(m.wr_reg_out));
            chk(m.id, "mem_re", 16'(mem_re), 16'(m.mem_re));
            chk(m.id, "mem_we", 16'(mem_we), 16'(m.mem_we));
            chk(m.id, "halted", 16'(halted), 16'(m.halted));
            if (m.chk_alu) chk(m.id, "alu_out", alu_out, m.alu_out);
            if (m.chk_disp) begin
               chk(m.id, "dig_sel", 16'(dig_sel), 16'(m.dig_sel));
               chk(m.id, "seg", 16'(seg), 16'(m.seg));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t ex(input int id, input logic v, input logic [15:0] alu, input bit ca,
                               input logic [3:0] fl, input logic pc, input logic [15:0] pt,
                               input logic wr, input logic re, input logic we, input logic h);
      exp_t e;
      e.id = id; e.out_valid = v; e.alu_out = alu; e.chk_alu = ca; e.flags = fl;
      e.pcsrc = pc; e.pctarget = pt; e.wr_reg_out = wr; e.mem_re = re; e.mem_we = we;
      e.halted = h; e.chk_disp = 1'b0; e.dig_sel = 4'h0; e.seg = 8'h00;
      return e;
   endfunction

   function automatic exp_t exd(input exp_t b, input logic [3:0] ds, input logic [7:0] sg);
      exp_t e;
      e = b; e.chk_disp = 1'b1; e.dig_sel = ds; e.seg = sg;
      return e;
   endfunction

   task automatic set_op(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      in_valid = v; opcode = op; alu1 = a; alu2 = b; isbranch = 1'b0; cond = 3'd0;
      wr_reg = 1'b0; wr_addr = 3'd2; mem_op = 2'd0; stall = 1'b0; flush = 1'b0;
      in_data = 16'h0000; mem_addr_in = 16'h0000; store_in = 16'h0000;
   endtask

   task automatic step(input exp_t e);
      @(posedge clk);
      sb.push_back(e);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      set_op(1'b0, 4'd0, 16'h0, 16'h0);
      step(exd(ex(1, 0, 16'h0000, 1, 4'h0, 0, 16'h0000, 0, 0, 0, 0), 4'h1, 8'hFC));
      rst_n = 1'b1;

      // ALU / flags / branch
      set_op(1, 4'd0, 16'h7FFF, 16'h0001); wr_reg = 1'b1;
      step(ex(2, 1, 16'h8000, 1, 4'h9, 0, 16'h0000, 1, 0, 0, 0));
      set_op(1, 4'd5, 16'h0003, 16'h0005);
      step(ex(3, 1, 16'hFFFE, 1, 4'hA, 0, 16'h0000, 0, 0, 0, 0));
      set_op(1, 4'd0, 16'h0, 16'h0); isbranch = 1'b1; cond = 3'd1; store_in = 16'h0040;
      step(ex(4, 1, 16'h0000, 1, 4'hA, 1, 16'h0040, 0, 0, 0, 0));
      set_op(0, 4'd0, 16'h0, 16'h0);
      step(ex(5, 0, 16'h0000, 0, 4'hA, 0, 16'h0040, 0, 0, 0, 0));
      set_op(1, 4'd5, 16'h0005, 16'h0005);
      step(ex(6, 1, 16'h0000, 1, 4'h4, 0, 16'h0040, 0, 0, 0, 0));
      set_op(1, 4'd0, 16'h0, 16'h0); isbranch = 1'b1; cond = 3'd3; store_in = 16'h0080;
      step(ex(7, 1, 16'h0000, 1, 4'h4, 0, 16'h0040, 0, 0, 0, 0));
      set_op(1, 4'd0, 16'h0, 16'h0); isbranch = 1'b1; cond = 3'd0; store_in = 16'h00C0;
      step(ex(8, 1, 16'h0000, 1, 4'h4, 1, 16'h00C0, 0, 0, 0, 0));

      // Stall holds everything but pcsrc; flush wins over stall
      for (int i = 0; i < 3; i++) begin
         set_op(1, 4'd0, 16'h0001, 16'h0001); wr_reg = 1'b1; mem_op = 2'd1; stall = 1'b1;
         step(ex(9 + i, 1, 16'h0000, 1, 4'h4, 0, 16'h00C0, 0, 0, 0, 0));
      end
      set_op(1, 4'd0, 16'h7FFF, 16'h0001); wr_reg = 1'b1; mem_op = 2'd1; stall = 1'b1; flush = 1'b1;
      step(ex(12, 0, 16'h0000, 0, 4'h4, 0, 16'h00C0, 0, 0, 0, 0));

      // Shifts and remaining ops
      set_op(1, 4'd8, 16'h8001, 16'h0001);
      step(ex(13, 1, 16'h0002, 1, 4'h2, 0, 16'h00C0, 0, 0, 0, 0));
      set_op(1, 4'd11, 16'h8000, 16'h000F);
      step(ex(14, 1, 16'hFFFF, 1, 4'h8, 0, 16'h00C0, 0, 0, 0, 0));
      set_op(1, 4'd9, 16'h8001, 16'h0004);
      step(ex(15, 1, 16'h0018, 1, 4'h0, 0, 16'h00C0, 0, 0, 0, 0));
      set_op(1, 4'd10, 16'h8001, 16'h0001);
      step(ex(16, 1, 16'h4000, 1, 4'h2, 0, 16'h00C0, 0, 0, 0, 0));
      set_op(1, 4'd1, 16'h8000, 16'h0001);
      step(ex(17, 1, 16'h7FFF, 1, 4'h1, 0, 16'h00C0, 0, 0, 0, 0));
      set_op(1, 4'd2, 16'hF0F0, 16'h0FF0);
      step(ex(18, 1, 16'h00F0, 1, 4'h0, 0, 16'h00C0, 0, 0, 0, 0));
      set_op(1, 4'd4, 16'h1234, 16'h1234);
      step(ex(19, 1, 16'h0000, 1, 4'h4, 0, 16'h00C0, 0, 0, 0, 0));
      set_op(1, 4'd6, 16'h0000, 16'hABCD); mem_op = 2'd2;
      step(ex(20, 1, 16'hABCD, 1, 4'h8, 0, 16'h00C0, 0, 0, 1, 0));
      set_op(1, 4'd12, 16'h0000, 16'h0000); in_data = 16'h5A5A; mem_op = 2'd1; wr_reg = 1'b1;
      step(ex(21, 1, 16'h5A5A, 1, 4'h8, 0, 16'h00C0, 1, 1, 0, 0));
      set_op(1, 4'd7, 16'h1234, 16'h0001);
      step(ex(22, 1, 16'h0000, 1, 4'h8, 0, 16'h00C0, 0, 0, 0, 0));
      set_op(1, 4'd3, 16'h00F0, 16'h0F00); mem_op = 2'd3; wr_reg = 1'b1;
      step(ex(23, 1, 16'h0FF0, 1, 4'h0, 0, 16'h00C0, 1, 0, 0, 0));

      // Display: reset to align the scan, then OUT 1A2F
      rst_n = 1'b0;
      set_op(0, 4'd0, 16'h0, 16'h0);
      step(exd(ex(24, 0, 16'h0000, 1, 4'h0, 0, 16'h0000, 0, 0, 0, 0), 4'h1, 8'hFC));
      rst_n = 1'b1;
      set_op(1, 4'd13, 16'h1A2F, 16'h0000);
      step(exd(ex(25, 1, 16'h1A2F, 1, 4'h0, 0, 16'h0000, 0, 0, 0, 0), 4'h1, 8'h8E));
      set_op(0, 4'd0, 16'h0, 16'h0);
      for (int k = 2; k <= 16; k++) begin
         step(exd(ex(24 + k, 0, 16'h0000, 0, 4'h0, 0, 16'h0000, 0, 0, 0, 0),
                  4'h1 << ((k / 4) % 4), segtab[(k / 4) % 4]));
      end

      // Halt, then reset mid-scan
      set_op(1, 4'd15, 16'h0, 16'h0); wr_reg = 1'b1;
      step(ex(41, 0, 16'h0000, 0, 4'h0, 0, 16'h0000, 0, 0, 0, 1));
      set_op(1, 4'd0, 16'h0001, 16'h0001); wr_reg = 1'b1; mem_op = 2'd2;
      step(ex(42, 0, 16'h0000, 0, 4'h0, 0, 16'h0000, 0, 0, 0, 1));
      set_op(1, 4'd0, 16'h0, 16'h0); isbranch = 1'b1; cond = 3'd4; store_in = 16'h0100;
      step(ex(43, 0, 16'h0000, 0, 4'h0, 0, 16'h0000, 0, 0, 0, 1));
      rst_n = 1'b0;
      set_op(0, 4'd0, 16'h0, 16'h0);
      step(exd(ex(44, 0, 16'h0000, 1, 4'h0, 0, 16'h0000, 0, 0, 0, 0), 4'h1, 8'hFC));
      rst_n = 1'b1;
      set_op(1, 4'd0, 16'h0001, 16'h0001); wr_reg = 1'b1;
      step(ex(45, 1, 16'h0002, 1, 4'h0, 0, 16'h0000, 1, 0, 0, 0));

      set_op(0, 4'd0, 16'h0, 16'h0);
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
